mem_lsu: RTL
============

# mem_lsu

Load/store unit between the core's data-side request interface and port B of the dual-port BRAM main memory. Each accepted request is checked for alignment and range. The unit then drives one memory access with the correct byte enables and replicated write data. For loads, it extracts, sign- or zero-extends, and returns the addressed bytes. It processes one request at a time, with a valid/ready handshake on both the request side and the response side.

## Interface
- MEM_SIZE, 8192: bytes of backing memory; must match the memory's MEM_SIZE; power of two.
- AW, $clog2(MEM_SIZE): memory address width (derived; not overridden).
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous assert, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size (mem_pkg::size_t): 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: zero-extend if 1, sign-extend if 0.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response present; held until taken.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  32  load result; 0 for stores and faults.
- rsp_fault  out  1  request was misaligned, out of range, or illegal size; no memory access occurred.
- mem_addr  out  AW  to memory addr_b.
- mem_wdata  out  32  to memory data_i_b.
- mem_rdata  in  32  from memory data_o_b.
- mem_data_en  out  4  to memory data_en_b.
- mem_write_en  out  1  to memory write_en_b.

## Operation
- FSM states (mem_pkg::lsu_state_t): IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch addr/we/size/unsigned/wdata and go to ISSUE. If the request faults, go to RESP instead, with rsp_fault=1.
- Fault conditions:
  - size 11;
  - half at an odd address;
  - word with addr[1:0]≠0;
  - req_addr ≥ MEM_SIZE.
- ISSUE:
  - mem_addr = latched addr[AW-1:0].
  - mem_data_en: byte → 1<<addr[1:0]; half → 4'b0011<<addr[1:0]; word → 4'b1111.
  - mem_write_en = latched we.
  - Next state: store → RESP; load → WAIT.
- Store data replication on mem_wdata: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- WAIT: mem_rdata is valid. Select lane k = addr[1:0], little-endian (byte k = bits 8k+7:8k). Extend to 32 bits per size and unsigned, register the result into rsp_rdata, and go to RESP.
- RESP: rsp_valid=1 with rsp_rdata and rsp_fault stable. On rsp_ready, go to IDLE.
- Outside ISSUE: mem_write_en=0 and mem_data_en=0. mem_addr and mem_wdata hold their last value.

## Timing
- Reset values:
  - state IDLE;
  - req_ready=1 (IDLE decode);
  - rsp_valid=0, rsp_rdata=0, rsp_fault=0;
  - mem_addr=0, mem_wdata=0, mem_data_en=0, mem_write_en=0.
- Reset asserted in any state returns immediately to IDLE. Reset asserted during ISSUE drops mem_write_en before the edge, so no write occurs. No pending response survives reset.
- Request accepted at edge E0. Timing from there:
  - Load: ISSUE in cycle E0+1; WAIT in E0+2; rsp_valid from E0+3. Memory read latency is one cycle.
  - Store: ISSUE in cycle E0+1, memory writes at the end of that cycle; rsp_valid from E0+2.
  - Fault: rsp_valid from E0+1; no ISSUE cycle.
- With rsp_ready held high, the unit returns to IDLE one cycle after rsp_valid rises. Throughput is one load per 4 cycles and one store per 3.
- req_ready is 0 in ISSUE, WAIT and RESP. req_* inputs are ignored there, so there is no simultaneous accept and respond.
- rsp_ready is ignored outside RESP.

## Structure
- mem_pkg: size_t enum (SIZE_B, SIZE_H, SIZE_W, SIZE_X), lsu_state_t enum, and byte-enable/extension helper functions.
- One sub-module: lsu_align. It is combinational and holds lane select, sign/zero extension, write replication and byte-enable generation, shared by the ISSUE and WAIT paths.
- mem_lsu keeps the FSM, request latch and response register.

## Test plan
- Reset mid-ISSUE of a store (0x40, 0xDEADBEEF, word) → no write; a subsequent word load of 0x40 returns the prior contents (0 after memory init).
- Word store 0x11223344 to 0x10, then byte loads of 0x10–0x13 → 0x44, 0x33, 0x22, 0x11; rsp_valid at E0+2 for the store and E0+3 for each load.
- Byte store 0x80 to 0x21 → mem_data_en=4'b0010 and mem_wdata=0x80808080. Signed byte load of 0x21 → 0xFFFFFF80; unsigned → 0x00000080.
- Half store 0xBEEF to 0x22, then signed half load of 0x22 → 0xFFFFBEEF. Bytes 0x20/0x21 are unchanged.
- Faults:
  - half at 0x03 → fault at E0+1, rsp_rdata=0, mem_write_en never high;
  - word at 0x06 → fault;
  - size 11 → fault;
  - addr 0x2000 (MEM_SIZE) → fault.
- Back-pressure: rsp_ready held low for 5 cycles in RESP → rsp_valid, rsp_rdata and rsp_fault stable, req_ready=0; release → IDLE the next cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the load/store unit: access sizes, FSM states,
// byte-enable generation, store replication and load extension.
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } lsu_state_t;

    function automatic logic [3:0] byte_en(size_t size, logic [1:0] off);
        case (size)
            SIZE_B:  return 4'b0001 << off;
            SIZE_H:  return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(size_t size, logic [31:0] data);
        case (size)
            SIZE_B:  return {4{data[7:0]}};
            SIZE_H:  return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] extend(size_t size, logic [1:0] off, logic uns,
                                           logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SIZE_B:  return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SIZE_H:  return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Core-side request/response handshake of the load/store unit.
interface mem_lsu_if import mem_pkg::*; ();
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    size_t       req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and write replication for the issue path,
// lane select and extension for the load-return path.
module lsu_align import mem_pkg::*; (
    input  size_t       size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    assign be_o    = byte_en(size_i, off_i);
    assign wdata_o = replicate(size_i, wdata_i);
    assign rdata_o = extend(size_i, off_i, uns_i, rdata_i);
endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: one request at a time from the core to BRAM port B, with
// alignment/range checking and a held response register.
module mem_lsu import mem_pkg::*; #(
    parameter  int unsigned MEM_SIZE = 8192,
    localparam int unsigned AW       = $clog2(MEM_SIZE)
) (
    input  logic            clk,
    input  logic            rst,
    mem_lsu_if.slave        bus,
    output logic [AW-1:0]   mem_addr_o,
    output logic [31:0]     mem_wdata_o,
    input  logic [31:0]     mem_rdata_i,
    output logic [3:0]      mem_data_en_o,
    output logic            mem_write_en_o
);
    lsu_state_t    state_q;
    logic [1:0]    off_q;
    logic          we_q;
    logic          uns_q;
    size_t         size_q;
    logic          rsp_valid_q;
    logic          rsp_fault_q;
    logic [31:0]   rsp_rdata_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [3:0]    mem_be_q;
    logic          mem_we_q;

    size_t       al_size;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        req_fault;

    // The aligner sees the live request in IDLE and the latched one afterwards.
    always_comb begin
        al_size = size_q;
        al_off  = off_q;
        if (state_q == IDLE) begin
            al_size = bus.req_size;
            al_off  = bus.req_addr[1:0];
        end
    end

    lsu_align u_align (
        .size_i  (al_size),
        .off_i   (al_off),
        .uns_i   (uns_q),
        .wdata_i (bus.req_wdata),
        .rdata_i (mem_rdata_i),
        .be_o    (al_be),
        .wdata_o (al_wdata),
        .rdata_o (al_rdata)
    );

    assign req_fault = (bus.req_size == SIZE_X)
                     | ((bus.req_size == SIZE_H) & bus.req_addr[0])
                     | ((bus.req_size == SIZE_W) & (|bus.req_addr[1:0]))
                     | (|bus.req_addr[31:AW]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            off_q       <= 2'b00;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= SIZE_B;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_we_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        off_q  <= bus.req_addr[1:0];
                        we_q   <= bus.req_we;
                        uns_q  <= bus.req_unsigned;
                        size_q <= bus.req_size;
                        if (req_fault) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_fault_q <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state_q     <= ISSUE;
                            mem_addr_q  <= bus.req_addr[AW-1:0];
                            mem_wdata_q <= al_wdata;
                            mem_be_q    <= al_be;
                            mem_we_q    <= bus.req_we;
                        end
                    end
                end
                ISSUE: begin
                    mem_be_q <= 4'h0;
                    mem_we_q <= 1'b0;
                    if (we_q) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_fault_q <= 1'b0;
                    rsp_rdata_q <= al_rdata;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_fault  = rsp_fault_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign mem_data_en_o  = mem_be_q;
    assign mem_write_en_o = mem_we_q;

endmodule
